// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution layer engine.
//
// Contents:
//   state_t  - layer sequencing states (IDLE, ACC, DRAIN, OUT, DONE)
//   REQ_W    - working width of the requantiser (must cover ACC_W)
//   requant  - bias add, optional ReLU and saturating fixed-point rescale
package conv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ACC,
      DRAIN,
      OUT,
      DONE
   } state_t;

   // Wide enough for any accumulator width this engine is configured with
   // (ACC_W = 2*WIDTH + clog2(TAPS)), with headroom for the bias add.
   localparam int REQ_W = 64;

   // Takes a sign-extended accumulator and bias, returns the requantised
   // lane value sign-extended to REQ_W; the caller keeps the low width bits.
   // The bias is aligned to the accumulator's 2*frac binary point before the
   // add. The result is floor(s / 2^frac), clamped to the signed range.
   function automatic logic signed [REQ_W-1:0] requant(
      input logic signed [REQ_W-1:0] acc,
      input logic signed [REQ_W-1:0] bias,
      input logic                    relu,
      input int                      frac,
      input int                      width
   );
      logic signed [REQ_W-1:0] s;
      logic signed [REQ_W-1:0] r;
      logic signed [REQ_W-1:0] hi;
      logic signed [REQ_W-1:0] lo;
      s  = acc + (bias <<< frac);
      hi = (REQ_W'(1) <<< (width - 1)) - REQ_W'(1);
      lo = -(REQ_W'(1) <<< (width - 1));
      if (relu && (s < 0)) begin
         r = '0;
      end else begin
         r = s >>> frac;
         if (r > hi) begin
            r = hi;
         end else if (r < lo) begin
            r = lo;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One multiply-accumulate lane of the convolution engine.
//
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   en        - accumulate this cycle's product
//   load      - when enabled, replace the accumulator with the product
//               instead of adding (first tap of a pixel)
//   pix       - signed input pixel tap
//   weight    - signed weight paired with pix
//   acc       - signed running sum
module conv_mac_lane #(
   parameter int WIDTH = 16,
   parameter int ACC_W = 42
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    load,
   input  logic signed [WIDTH-1:0] pix,
   input  logic signed [WIDTH-1:0] weight,
   output logic signed [ACC_W-1:0] acc
);

   logic signed [2*WIDTH-1:0] product;
   logic signed [ACC_W-1:0]   product_ext;

   assign product     = pix * weight;
   assign product_ext = ACC_W'(product);

   // Loading on the first product avoids a dedicated clear cycle per pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (en) begin
         acc <= load ? product_ext : acc + product_ext;
      end
   end

endmodule

// File: rtl/conv_layer_engine.sv
// Parametrised convolution layer engine.
//
// Streams one input tap per accepted beat into DSP_NO parallel MAC lanes,
// drives the weight-ROM address, then per output pixel adds bias, applies
// optional ReLU and requantises with saturation. CHOUT is folded into
// CHOUT/DSP_NO passes over the whole input stream.
//
// Ports:
//   clk, rst             - clock and synchronous active-high reset
//   start, relu_en       - begin a layer (IDLE only); ReLU select latched at start
//   ifm, ifm_valid/ready - input tap stream, tap-major per output pixel
//   w_addr, w_data       - weight ROM address (pass*TAPS+tap) and 1-cycle-late word
//   bias                 - per-lane bias for the current pass
//   ofm, ofm_valid/ready - requantised result lanes
//   busy, done           - layer in progress; 1-cycle pulse after last output
module conv_layer_engine
   import conv_pkg::*;
#(
   parameter int DSP_NO     = 256,
   parameter int WIDTH      = 16,
   parameter int FRAC       = 8,
   parameter int KERNEL_DIM = 3,
   parameter int CHIN       = 112,
   parameter int CHOUT      = 256,
   parameter int OUT_PIX    = 64,
   localparam int TAPS      = KERNEL_DIM * KERNEL_DIM * CHIN,
   localparam int PASSES    = CHOUT / DSP_NO,
   localparam int ACC_W     = 2 * WIDTH + $clog2(TAPS),
   localparam int ADDR_W    = $clog2(TAPS * PASSES)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      relu_en,
   input  logic [WIDTH-1:0]          ifm,
   input  logic                      ifm_valid,
   output logic                      ifm_ready,
   output logic [ADDR_W-1:0]         w_addr,
   input  logic [DSP_NO*WIDTH-1:0]   w_data,
   input  logic [DSP_NO*WIDTH-1:0]   bias,
   output logic [DSP_NO*WIDTH-1:0]   ofm,
   output logic                      ofm_valid,
   input  logic                      ofm_ready,
   output logic                      busy,
   output logic                      done
);

   localparam int TAP_W  = (TAPS > 1)    ? $clog2(TAPS)    : 1;
   localparam int PIX_W  = (OUT_PIX > 1) ? $clog2(OUT_PIX) : 1;
   localparam int PASS_W = (PASSES > 1)  ? $clog2(PASSES)  : 1;

   state_t state;
   state_t next_state;

   logic [TAP_W-1:0]        tap_cnt;
   logic [PIX_W-1:0]        pix_cnt;
   logic [PASS_W-1:0]       pass_cnt;
   logic                    drain_cnt;
   logic                    relu_q;
   logic signed [WIDTH-1:0] ifm_q;
   logic                    mac_en;
   logic                    mac_load;
   logic [DSP_NO*WIDTH-1:0] ofm_next;

   logic accept;
   logic ofm_hs;
   logic last_tap;
   logic last_pix;
   logic last_pass;

   assign accept    = ifm_valid && ifm_ready;
   assign ofm_hs    = ofm_valid && ofm_ready;
   assign last_tap  = (tap_cnt == TAP_W'(TAPS - 1));
   assign last_pix  = (pix_cnt == PIX_W'(OUT_PIX - 1));
   assign last_pass = (pass_cnt == PASS_W'(PASSES - 1));

   // Address follows the counters directly so it moves on the accepting edge.
   assign w_addr = ADDR_W'(int'(pass_cnt) * TAPS + int'(tap_cnt));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // DRAIN lasts two cycles: one for the registered tap to meet its ROM word
   // and be accumulated, one for the final sum to settle into requantisation.
   always_comb begin
      next_state = state;
      ifm_ready  = 1'b0;
      ofm_valid  = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               next_state = ACC;
            end
         end
         ACC: begin
            ifm_ready = 1'b1;
            if (accept && last_tap) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_cnt) begin
               next_state = OUT;
            end
         end
         OUT: begin
            ofm_valid = 1'b1;
            if (ofm_hs) begin
               next_state = (last_pix && last_pass) ? DONE : ACC;
            end
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Tap, pixel and pass counters; each wraps to zero at its last value so
   // the engine is back at pass 0, pixel 0, tap 0 when the layer completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         tap_cnt   <= '0;
         pix_cnt   <= '0;
         pass_cnt  <= '0;
         drain_cnt <= 1'b0;
         relu_q    <= 1'b0;
      end else begin
         if ((state == IDLE) && start) begin
            relu_q <= relu_en;
         end
         if (accept) begin
            tap_cnt <= last_tap ? '0 : tap_cnt + 1'b1;
         end
         if (state == DRAIN) begin
            drain_cnt <= ~drain_cnt;
         end
         if (ofm_hs) begin
            if (!last_pix) begin
               pix_cnt <= pix_cnt + 1'b1;
            end else begin
               pix_cnt  <= '0;
               pass_cnt <= last_pass ? '0 : pass_cnt + 1'b1;
            end
         end
      end
   end

   // The tap is held one stage so it lines up with the ROM word that the
   // same address produces one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         ifm_q    <= '0;
         mac_en   <= 1'b0;
         mac_load <= 1'b0;
      end else begin
         mac_en   <= accept;
         mac_load <= accept && (tap_cnt == '0);
         if (accept) begin
            ifm_q <= ifm;
         end
      end
   end

   for (genvar i = 0; i < DSP_NO; i++) begin : g_lane
      logic signed [ACC_W-1:0] acc;

      conv_mac_lane #(
         .WIDTH (WIDTH),
         .ACC_W (ACC_W)
      ) u_lane (
         .clk    (clk),
         .rst    (rst),
         .en     (mac_en),
         .load   (mac_load),
         .pix    (ifm_q),
         .weight (w_data[i*WIDTH +: WIDTH]),
         .acc    (acc)
      );

      assign ofm_next[i*WIDTH +: WIDTH] = WIDTH'(requant(REQ_W'(acc),
         REQ_W'($signed(bias[i*WIDTH +: WIDTH])), relu_q, FRAC, WIDTH));
   end

   // Result is captured once per pixel and held through any output stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         ofm <= '0;
      end else if ((state == DRAIN) && drain_cnt) begin
         ofm <= ofm_next;
      end
   end

endmodule
